// File: rtl/cpu_brc_pkg.sv
// Shared types for the branch resolution unit: funct3 encodings, result record and decision helper.
// Optional perf counters in the top are enabled by defining BRU_PERF_CNT_EN.
package cpu_brc_pkg;

   localparam int unsigned BRC_XLEN = 32;
   localparam int unsigned PC_INC   = 4;

   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } brc_funct3_e;

   typedef struct packed {
      logic                taken;
      logic                mispredict;
      logic                illegal;
      logic [BRC_XLEN-1:0] redirect_pc;
   } brc_result_t;

   // Returns {illegal, taken}; funct3 010/011 are not branches and never take.
   function automatic logic [1:0] brc_decide(input logic [2:0] f3, input logic eq,
                                             input logic lt, input logic ltu);
      logic [1:0] r;
      r = 2'b00;
      case (brc_funct3_e'(f3))
         BEQ:     r = {1'b0, eq};
         BNE:     r = {1'b0, ~eq};
         BLT:     r = {1'b0, lt};
         BGE:     r = {1'b0, ~lt};
         BLTU:    r = {1'b0, ltu};
         BGEU:    r = {1'b0, ~ltu};
         default: r = 2'b10;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational operand comparator producing equal, signed-less-than and unsigned-less-than.
module branch_cmp #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   output logic            o_eq,
   output logic            o_lt,
   output logic            o_ltu
);

   assign o_eq  = ~|(i_rs1 ^ i_rs2);
   assign o_lt  = $signed(i_rs1) < $signed(i_rs2);
   assign o_ltu = i_rs1 < i_rs2;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: single-entry valid/ready result register with flush and redirect.
// Define BRU_PERF_CNT_EN to add the br_cnt_o / mispred_cnt_o performance counters.
module branch_resolve_unit
   import cpu_brc_pkg::*;
#(
   parameter int unsigned     XLEN     = BRC_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic            pred_taken_i,
   input  logic            flush_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic            taken_o,
   output logic            mispredict_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            illegal_o
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [31:0]     br_cnt_o,
   output logic [31:0]     mispred_cnt_o
`endif
);

   logic        w_eq, w_lt, w_ltu;
   logic        w_accept;
   logic [1:0]  w_dec;
   brc_result_t w_res;
   brc_result_t r_res;
   logic        r_out_valid;

   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .i_rs1 (rs1_i),
      .i_rs2 (rs2_i),
      .o_eq  (w_eq),
      .o_lt  (w_lt),
      .o_ltu (w_ltu)
   );

   assign in_ready_o = ~r_out_valid | out_ready_i;
   assign w_accept   = in_valid_i & in_ready_o & ~flush_i;

   always_comb begin
      w_dec                = brc_decide(funct3_i, w_eq, w_lt, w_ltu);
      w_res.illegal        = w_dec[1];
      w_res.taken          = w_dec[0];
      w_res.mispredict     = ~w_dec[1] & (w_dec[0] ^ pred_taken_i);
      w_res.redirect_pc    = w_dec[0] ? (pc_i + imm_i) : (pc_i + XLEN'(PC_INC));
   end

   // Flush clears the flags but leaves the last redirect PC on the bus.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_out_valid       <= 1'b0;
         r_res.taken       <= 1'b0;
         r_res.mispredict  <= 1'b0;
         r_res.illegal     <= 1'b0;
         r_res.redirect_pc <= RESET_PC;
      end else if (flush_i) begin
         r_out_valid       <= 1'b0;
         r_res.taken       <= 1'b0;
         r_res.mispredict  <= 1'b0;
         r_res.illegal     <= 1'b0;
      end else if (w_accept) begin
         r_out_valid       <= 1'b1;
         r_res             <= w_res;
      end else if (out_ready_i) begin
         r_out_valid       <= 1'b0;
      end
   end

   assign out_valid_o   = r_out_valid;
   assign taken_o       = r_res.taken;
   assign mispredict_o  = r_res.mispredict;
   assign illegal_o     = r_res.illegal;
   assign redirect_pc_o = r_res.redirect_pc;

`ifdef BRU_PERF_CNT_EN
   logic        w_count;
   logic [31:0] r_br_cnt;
   logic [31:0] r_mispred_cnt;

   // Only legal branches delivered to the consumer are counted; flush does not clear.
   assign w_count = r_out_valid & out_ready_i & ~r_res.illegal;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_br_cnt      <= '0;
         r_mispred_cnt <= '0;
      end else if (w_count) begin
         r_br_cnt      <= r_br_cnt + 32'd1;
         if (r_res.mispredict) r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
   end

   assign br_cnt_o      = r_br_cnt;
   assign mispred_cnt_o = r_mispred_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios plus randomized traffic vs a reference model.
module tb_branch_resolve_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [2:0]  funct3_i;
   logic [31:0] rs1_i, rs2_i, pc_i, imm_i;
   logic        pred_taken_i;
   logic        flush_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic        taken_o;
   logic        mispredict_o;
   logic [31:0] redirect_pc_o;
   logic        illegal_o;
`ifdef BRU_PERF_CNT_EN
   logic [31:0] br_cnt_o, mispred_cnt_o;
   int unsigned m_br_cnt, m_mis_cnt;
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;

   // expected entry packing: {taken, mispredict, illegal, redirect_pc}
   logic [34:0] exp_q[$];
   logic [34:0] idle_exp;

   branch_resolve_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .funct3_i      (funct3_i),
      .rs1_i         (rs1_i),
      .rs2_i         (rs2_i),
      .pc_i          (pc_i),
      .imm_i         (imm_i),
      .pred_taken_i  (pred_taken_i),
      .flush_i       (flush_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .taken_o       (taken_o),
      .mispredict_o  (mispredict_o),
      .redirect_pc_o (redirect_pc_o),
      .illegal_o     (illegal_o)
`ifdef BRU_PERF_CNT_EN
      ,
      .br_cnt_o      (br_cnt_o),
      .mispred_cnt_o (mispred_cnt_o)
`endif
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [34:0] model(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] pc,
                                         input logic [31:0] imm, input logic pred);
      longint      sa, sb, ua, ub;
      logic        t, ill, mis;
      logic [31:0] tgt;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      t = 1'b0;
      ill = 1'b0;
      case (f3)
         3'd0: t = (a == b);
         3'd1: t = (a != b);
         3'd4: t = (sa < sb);
         3'd5: t = (sa >= sb);
         3'd6: t = (ua < ub);
         3'd7: t = (ua >= ub);
         default: ill = 1'b1;
      endcase
      tgt = t ? pc + imm : pc + 32'd4;
      mis = !ill && (t != pred);
      return {t, mis, ill, tgt};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                        input logic pred, input logic rdy, input logic fl);
      logic acc;
      in_valid_i = v; funct3_i = f3; rs1_i = a; rs2_i = b; pc_i = pc; imm_i = imm;
      pred_taken_i = pred; out_ready_i = rdy; flush_i = fl;
      @(negedge clk);
      acc = !rst_i && v && (!out_valid_o || rdy) && !fl;
      @(posedge clk);
      if (acc) exp_q.push_back(model(f3, a, b, pc, imm, pred));
      #1;
   endtask

   task automatic idle_cycle(input logic rdy);
      drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, rdy, 1'b0);
   endtask

   task automatic do_reset(input int n);
      rst_i = 1'b1;
      in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
      repeat (n) @(posedge clk);
      #1 rst_i = 1'b0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [34:0] cur;
      logic [34:0] act;
      act = {taken_o, mispredict_o, illegal_o, redirect_pc_o};
      if (rst_i) begin
         exp_q.delete();
         idle_exp = {3'b000, RESET_PC};
`ifdef BRU_PERF_CNT_EN
         m_br_cnt = 0;
         m_mis_cnt = 0;
`endif
      end else begin
         check("in_ready", {34'd0, in_ready_o}, {34'd0, (!out_valid_o || out_ready_i)});
`ifdef BRU_PERF_CNT_EN
         check("br_cnt", {3'd0, br_cnt_o}, {3'd0, 32'(m_br_cnt)});
         check("mispred_cnt", {3'd0, mispred_cnt_o}, {3'd0, 32'(m_mis_cnt)});
`endif
         if (out_valid_o) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", {34'd0, out_valid_o}, 35'd0);
            end else begin
               cur = exp_q[0];
               check("result", act, cur);
               idle_exp = cur;
`ifdef BRU_PERF_CNT_EN
               if (out_ready_i && !cur[32]) begin
                  m_br_cnt++;
                  if (cur[33]) m_mis_cnt++;
               end
`endif
               if (out_ready_i || flush_i) void'(exp_q.pop_front());
            end
         end else begin
            check("valid_missing", {34'd0, out_valid_o}, {34'd0, (exp_q.size() != 0)});
            check("idle_outputs", act, idle_exp);
         end
         if (flush_i) idle_exp[34:32] = 3'b000;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_i = 1'b1; in_valid_i = 1'b0; funct3_i = 3'd0; rs1_i = '0; rs2_i = '0;
      pc_i = '0; imm_i = '0; pred_taken_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
      idle_exp = {3'b000, RESET_PC};
      do_reset(2);
      idle_cycle(1'b1);

      // 1: BEQ equal operands, taken and mispredicted
      drive(1'b1, 3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h100, 32'h20, 1'b0, 1'b1, 1'b0);
      check("t1_direct", {taken_o, mispredict_o, illegal_o, redirect_pc_o}, {3'b110, 32'h120});
      idle_cycle(1'b1);

      // 2: signed vs unsigned compare of -1 and 1
      drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1, 1'b1, 1'b0);
      check("t2_bltu", {taken_o, mispredict_o, illegal_o, redirect_pc_o}, {3'b010, 32'h204});
      idle_cycle(1'b1);

      // 3: backpressure for 3 cycles, then back-to-back reload
      drive(1'b1, 3'b001, 32'd5, 32'd6, 32'h300, 32'h10, 1'b1, 1'b0, 1'b0);
      repeat (3) drive(1'b1, 3'b101, 32'd7, 32'd3, 32'h400, 32'h8, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 3'b101, 32'd7, 32'd3, 32'h400, 32'h8, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 3'b111, 32'd1, 32'd2, 32'h500, 32'h8, 1'b0, 1'b1, 1'b0);
      idle_cycle(1'b1);

      // 4: flush with a held result and an incoming op
      drive(1'b1, 3'b000, 32'd9, 32'd9, 32'h600, 32'h4, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 3'b000, 32'd1, 32'd1, 32'h700, 32'h4, 1'b1, 1'b0, 1'b1);
      idle_cycle(1'b1);

      // 5: PC wrap and illegal funct3
      drive(1'b1, 3'b001, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20, 1'b1, 1'b1, 1'b0);
      check("t5_wrap", {3'd0, redirect_pc_o}, {3'd0, 32'h0000_0010});
      drive(1'b1, 3'b011, 32'd1, 32'd1, 32'h800, 32'h20, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 3'b010, 32'd1, 32'd2, 32'h900, 32'h20, 1'b0, 1'b1, 1'b0);
      idle_cycle(1'b1);

`ifdef BRU_PERF_CNT_EN
      // 6: 10 branches with 3 mispredicts, then reset
      do_reset(1);
      for (int i = 0; i < 10; i++)
         drive(1'b1, 3'b000, 32'd4, 32'd4, 32'h1000, 32'h10, (i < 3) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      idle_cycle(1'b1);
      idle_cycle(1'b1);
      check("t6_br_cnt", {3'd0, br_cnt_o}, {3'd0, 32'd10});
      check("t6_mis_cnt", {3'd0, mispred_cnt_o}, {3'd0, 32'd3});
      do_reset(1);
      check("t6_br_cnt_rst", {3'd0, br_cnt_o}, 35'd0);
      check("t6_mis_cnt_rst", {3'd0, mispred_cnt_o}, 35'd0);
`endif

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [31:0] a, b;
         a = $urandom();
         b = ($urandom_range(0, 3) == 0) ? a : $urandom();
         if ($urandom_range(0, 99) == 0) begin
            do_reset($urandom_range(1, 2));
         end else begin
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b,
                  $urandom(), $urandom(), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
         end
      end

      repeat (3) idle_cycle(1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
